wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL take parameter PRIO_RESET, default 0, meaning the requester index (0 or 1) that holds priority after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on posedge clk.
REQ-004 The block SHALL have ports req0_valid (input, 1), req0_rd (input, 5) and req0_data (input, 32): the requester-0 writeback request (ALU path).
REQ-005 The block SHALL have port req0_ready, output, 1 bit: requester-0 grant.
REQ-006 The block SHALL have ports req1_valid (input, 1), req1_rd (input, 5), req1_data (input, 32) and req1_ready (output, 1): the same set for requester 1 (load/multi-cycle path).
REQ-007 The block SHALL have ports RegWrite (output, 1), RW (output, 5) and WD (output, 32): the registered register-file write port.
REQ-008 The block SHALL have ports R1 and R2, input, 5 bits each: the register-file read addresses for the current cycle.
REQ-009 The block SHALL have ports fwd_hit1 and fwd_hit2, output, 1 bit each: the pending write matches R1 or R2 respectively.
REQ-010 The block SHALL have port fwd_data, output, 32 bits: forwarded data, equal to WD.
REQ-011 The block SHALL have port wr_count, output, 16 bits: the count of committed non-zero-register writes.

Function
REQ-012 A handshake SHALL complete in a cycle where reqN_valid=1 and reqN_ready=1 at posedge clk.
REQ-013 Ready SHALL be combinational from the valid inputs, the priority pointer and rst: at most one ready is high per cycle, and no ready is asserted without the matching valid.
REQ-014 The grant SHALL follow these rules:
- Only one valid: grant it.
- Both valid: grant the requester named by ptr.
- Neither valid: no grant.
REQ-015 After any completed handshake, ptr SHALL load the index of the requester not granted; with no grant, ptr SHALL hold.
REQ-016 When a handshake completes with rd!=0, the next edge SHALL load RegWrite=1, RW=rd and WD=data.
- The result is a 1-cycle latency from handshake to the write port.
REQ-017 When a handshake completes with rd=0, the handshake SHALL complete normally and update ptr, but the next edge SHALL load RegWrite=0; RW and WD may load.
REQ-018 In any cycle with no completed handshake, the next edge SHALL load RegWrite=0 and RW/WD SHALL hold.
REQ-019 The output stage SHALL never back-pressure, so sustained throughput is one write per cycle.
REQ-020 A requester whose valid is high and not granted SHALL be granted within 2 cycles, even when the other requester holds valid continuously.
REQ-021 The hit outputs SHALL be defined as:
- fwd_hit1 = RegWrite & (RW==R1) & (R1!=0).
- fwd_hit2 likewise for R2.
- All three are combinational.
REQ-022 fwd_data SHALL equal WD at all times.
REQ-023 wr_count SHALL increment by 1 on each edge where RegWrite=1 is loaded, and SHALL saturate at 16'hFFFF.
REQ-024 Requesters SHALL hold valid, rd and data stable until ready; a bench assertion SHALL flag a valid drop or payload change before ready as a protocol error.
REQ-025 Two requests to the same rd SHALL be written in grant order, with no merging or reordering.

Reset
REQ-026 Reset occurs when rst=0 at posedge clk; on that edge the block SHALL load:
- RegWrite=0, RW=0, WD=0.
- wr_count=0.
- ptr=PRIO_RESET.
REQ-027 While rst=0, req0_ready and req1_ready SHALL be 0, and no handshake completes.
REQ-028 Reset asserted mid-stream SHALL discard the write staged on that edge, and SHALL not commit the cycle's pending request.
REQ-029 On the first edge with rst=1, the block SHALL arbitrate normally using ptr=PRIO_RESET.

Verification
REQ-030 Single write: rst released, req0 {valid, rd=5, data=32'hDEADBEEF} for 1 cycle -> req0_ready=1 that cycle; next cycle RegWrite=1, RW=5, WD=32'hDEADBEEF; cycle after, RegWrite=0; wr_count=1.
REQ-031 Contention: PRIO_RESET=0, both valid continuously (rd=1/2, data=A/B) -> grants 0,1,0,1...; RW sequence 1,2,1,2 starting one cycle later; no starvation.
REQ-032 Zero register: req1 {rd=0, data=32'h1234} -> req1_ready=1, RegWrite stays 0, wr_count unchanged, ptr flips to 0.
REQ-033 Forwarding: write to rd=7 staged (RegWrite=1, RW=7) with R1=7 and R2=0 -> fwd_hit1=1, fwd_hit2=0, fwd_data=WD; with R1=0 and RW=0 -> fwd_hit1=0.
REQ-034 Reset mid-operation: both valid, rst=0 for one edge -> both readies 0, RegWrite=0, wr_count=0 after the edge; next cycle the grant goes to PRIO_RESET.
REQ-035 Saturation: force 65536+ committed writes -> wr_count holds at 16'hFFFF.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-requester writeback arbiter feeding a registered register-file write port.
// Round-robin on contention, with forwarding of the staged write and a commit counter.
module wb_arbiter #(
    parameter int unsigned PRIO_RESET = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [4:0]  req0_rd,
    input  logic [31:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [4:0]  req1_rd,
    input  logic [31:0] req1_data,
    output logic        req1_ready,
    output logic        RegWrite,
    output logic [4:0]  RW,
    output logic [31:0] WD,
    input  logic [4:0]  R1,
    input  logic [4:0]  R2,
    output logic        fwd_hit1,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data,
    output logic [15:0] wr_count
);

    localparam logic PTR_INIT = (PRIO_RESET != 0);

    logic        ptr_q, ptr_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rw_q, rw_d;
    logic [31:0] wd_q, wd_d;
    logic [15:0] cnt_q, cnt_d;

    logic        gnt0, gnt1, hs;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    // ptr names the winner only when both requesters are valid
    assign gnt0 = rst & req0_valid & (~req1_valid | ~ptr_q);
    assign gnt1 = rst & req1_valid & (~req0_valid | ptr_q);
    assign hs   = gnt0 | gnt1;

    assign sel_rd   = gnt1 ? req1_rd : req0_rd;
    assign sel_data = gnt1 ? req1_data : req0_data;

    always_comb begin
        ptr_d      = ptr_q;
        regwrite_d = 1'b0;
        rw_d       = rw_q;
        wd_d       = wd_q;
        cnt_d      = cnt_q;
        if (hs) begin
            ptr_d      = gnt0;
            regwrite_d = (sel_rd != 5'd0);
            rw_d       = sel_rd;
            wd_d       = sel_data;
            if (sel_rd != 5'd0 && cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q      <= PTR_INIT;
            regwrite_q <= 1'b0;
            rw_q       <= 5'd0;
            wd_q       <= 32'd0;
            cnt_q      <= 16'd0;
        end else begin
            ptr_q      <= ptr_d;
            regwrite_q <= regwrite_d;
            rw_q       <= rw_d;
            wd_q       <= wd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign RegWrite   = regwrite_q;
    assign RW         = rw_q;
    assign WD         = wd_q;
    assign fwd_hit1   = regwrite_q & (rw_q == R1) & (R1 != 5'd0);
    assign fwd_hit2   = regwrite_q & (rw_q == R2) & (R2 != 5'd0);
    assign fwd_data   = wd_q;
    assign wr_count   = cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single write, contention, x0, forwarding,
// mid-stream reset and counter saturation, plus a requester protocol monitor.
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        RegWrite;
    logic [4:0]  RW;
    logic [31:0] WD;
    logic [4:0]  R1;
    logic [4:0]  R2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
    logic [15:0] wr_count;

    int checks = 0;
    int failures = 0;

    wb_arbiter #(.PRIO_RESET(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rd(req0_rd),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .RegWrite(RegWrite), .RW(RW), .WD(WD),
        .R1(R1), .R2(R2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data(fwd_data), .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // A pending request must keep valid and payload until it is granted
    logic        pv0 = 1'b0, pv1 = 1'b0;
    logic [4:0]  prd0, prd1;
    logic [31:0] pd0, pd1;
    always @(negedge clk) begin
        if (pv0) chk("proto0", {31'd0, req0_valid && req0_rd == prd0 && req0_data == pd0}, 32'd1);
        if (pv1) chk("proto1", {31'd0, req1_valid && req1_rd == prd1 && req1_data == pd1}, 32'd1);
        pv0 = req0_valid & ~req0_ready;
        pv1 = req1_valid & ~req1_ready;
        prd0 = req0_rd; pd0 = req0_data;
        prd1 = req1_rd; pd1 = req1_data;
    end

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_rd = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = 32'd0;
        R1 = 5'd0; R2 = 5'd0;

        tick(); tick(); mid();
        chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("rst_rw", {27'd0, RW}, 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_count", {16'd0, wr_count}, 32'd0);

        // single write
        tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        mid();
        chk("single_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("single_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        mid();
        chk("single_we", {31'd0, RegWrite}, 32'd1);
        chk("single_rw", {27'd0, RW}, 32'd5);
        chk("single_wd", WD, 32'hDEADBEEF);
        chk("single_cnt", {16'd0, wr_count}, 32'd1);
        tick(); mid();
        chk("single_we_off", {31'd0, RegWrite}, 32'd0);
        chk("single_cnt2", {16'd0, wr_count}, 32'd1);

        // x0 write from req1 flips ptr back to 0
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h1234;
        #1;
        chk("zero_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("zero_rdy0", {31'd0, req0_ready}, 32'd0);
        tick();
        req1_valid = 1'b0;
        mid();
        chk("zero_we", {31'd0, RegWrite}, 32'd0);
        chk("zero_cnt", {16'd0, wr_count}, 32'd1);

        // contention alternates starting with requester 0
        req0_valid = 1'b1; req0_rd = 5'd1; req0_data = 32'hA;
        req1_valid = 1'b1; req1_rd = 5'd2; req1_data = 32'hB;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cont_rdy0", {31'd0, req0_ready}, {31'd0, i % 2 == 0});
            chk("cont_rdy1", {31'd0, req1_ready}, {31'd0, i % 2 == 1});
            if (i > 0) begin
                chk("cont_we", {31'd0, RegWrite}, 32'd1);
                chk("cont_rw", {27'd0, RW}, (i % 2 == 1) ? 32'd1 : 32'd2);
                chk("cont_wd", WD, (i % 2 == 1) ? 32'hA : 32'hB);
            end
            tick(); mid();
        end
        req1_valid = 1'b0;
        #1;
        chk("cont_tail_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("cont_tail_rw", {27'd0, RW}, 32'd2);
        tick();
        req0_valid = 1'b0;
        mid();
        chk("cont_last_rw", {27'd0, RW}, 32'd1);
        chk("cont_last_wd", WD, 32'hA);
        chk("cont_cnt", {16'd0, wr_count}, 32'd8);

        // forwarding of a staged write to r7
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h77;
        tick();
        req0_valid = 1'b0;
        mid();
        R1 = 5'd7; R2 = 5'd0;
        #1;
        chk("fwd_we", {31'd0, RegWrite}, 32'd1);
        chk("fwd_hit1", {31'd0, fwd_hit1}, 32'd1);
        chk("fwd_hit2_r0", {31'd0, fwd_hit2}, 32'd0);
        chk("fwd_data", fwd_data, 32'h77);
        R2 = 5'd7;
        #1;
        chk("fwd_hit2", {31'd0, fwd_hit2}, 32'd1);
        R1 = 5'd0;
        #1;
        chk("fwd_hit1_r0", {31'd0, fwd_hit1}, 32'd0);
        tick(); mid();
        R1 = 5'd7;
        #1;
        chk("fwd_hit1_idle", {31'd0, fwd_hit1}, 32'd0);
        chk("fwd_cnt", {16'd0, wr_count}, 32'd9);

        // reset mid-operation with both requesters valid (ptr is 1 here)
        rst = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h33;
        req1_valid = 1'b1; req1_rd = 5'd4; req1_data = 32'h44;
        #1;
        chk("mrst_rdy0", {31'd0, req0_ready}, 32'd0);
        chk("mrst_rdy1", {31'd0, req1_ready}, 32'd0);
        tick();
        rst = 1'b1;
        mid();
        chk("mrst_we", {31'd0, RegWrite}, 32'd0);
        chk("mrst_cnt", {16'd0, wr_count}, 32'd0);
        chk("mrst_gnt0", {31'd0, req0_ready}, 32'd1);
        chk("mrst_gnt1", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        mid();
        chk("mrst_next_rdy1", {31'd0, req1_ready}, 32'd1);
        chk("mrst_rw3", {27'd0, RW}, 32'd3);
        tick();
        req1_valid = 1'b0;
        mid();
        chk("mrst_rw4", {27'd0, RW}, 32'd4);
        chk("mrst_wd4", WD, 32'h44);
        chk("mrst_cnt2", {16'd0, wr_count}, 32'd2);

        // saturation of the commit counter
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h99;
        repeat (65540) tick();
        req0_valid = 1'b0;
        mid();
        chk("sat_cnt", {16'd0, wr_count}, 32'h0000FFFF);
        tick(); mid();
        chk("sat_hold", {16'd0, wr_count}, 32'h0000FFFF);
        chk("sat_we_off", {31'd0, RegWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
